// File: rtl/regfile_pipe_if.sv
// rtl/regfile_pipe_if.sv - write, read, debug and ready signal bundle for regfile_pipe
interface regfile_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic              ready;

    modport master (
        output we, waddr, wdata, raddr1, raddr2, dbg_addr,
        input  rdata1, rdata2, dbg_data, ready
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, dbg_addr,
        output rdata1, rdata2, dbg_data, ready
    );
endinterface

// File: rtl/regfile_pipe.sv
// rtl/regfile_pipe.sv - two-read-port register file with registered outputs and init sweep
module regfile_pipe #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic          clock,
    input  logic          reset,
    regfile_pipe_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] init_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              run_wr_ok;
    logic [DATA_W-1:0] rd1_next;
    logic [DATA_W-1:0] rd2_next;

    logic              ready_q;
    logic [DATA_W-1:0] rdata1_q;
    logic [DATA_W-1:0] rdata2_q;
    logic [DATA_W-1:0] dbg_data_q;

    logic              zero_w;
    logic              zero_r1;
    logic              zero_r2;

    assign zero_w  = (ZERO_REG != 0) && (bus.waddr  == '0);
    assign zero_r1 = (ZERO_REG != 0) && (bus.raddr1 == '0);
    assign zero_r2 = (ZERO_REG != 0) && (bus.raddr2 == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // The sweep leaves INIT on the edge that writes the last entry.
    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (&init_cnt) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            init_cnt <= '0;
        end else if (state == INIT) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    assign run_wr_ok = (state == RUN) && bus.we && !zero_w;

    // Sweep value at entry 0 is already zero, so ZERO_REG needs no special case here.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = init_cnt;
        mem_wdata = DATA_W'(init_cnt);
        if (!reset) begin
            if (state == INIT) begin
                mem_we = 1'b1;
            end else if (run_wr_ok) begin
                mem_we    = 1'b1;
                mem_waddr = bus.waddr;
                mem_wdata = bus.wdata;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        rd1_next = mem[bus.raddr1];
        rd2_next = mem[bus.raddr2];
        if (run_wr_ok && (bus.waddr == bus.raddr1)) rd1_next = bus.wdata;
        if (run_wr_ok && (bus.waddr == bus.raddr2)) rd2_next = bus.wdata;
        if (zero_r1) rd1_next = '0;
        if (zero_r2) rd2_next = '0;
    end

    // Debug port sees the array only, never the in-flight write.
    always_ff @(posedge clock) begin
        if (reset || (state == INIT)) begin
            rdata1_q   <= '0;
            rdata2_q   <= '0;
            dbg_data_q <= '0;
        end else begin
            rdata1_q   <= rd1_next;
            rdata2_q   <= rd2_next;
            dbg_data_q <= mem[bus.dbg_addr];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= (state_next == RUN);
        end
    end

    assign bus.ready    = ready_q;
    assign bus.rdata1   = rdata1_q;
    assign bus.rdata2   = rdata2_q;
    assign bus.dbg_data = dbg_data_q;
endmodule

// File: doc/regfile_pipe.md
REGFILE_PIPE -- requirements
Module: regfile_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter ZERO_REG, default 1; when 1, entry 0 is hardwired zero.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clock  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port we  input  1  write enable.
REQ-007 SHALL have port waddr  input  ADDR_W  write address.
REQ-008 SHALL have port wdata  input  DATA_W  write data.
REQ-009 SHALL have ports raddr1, raddr2  input  ADDR_W  read addresses, ports 1 and 2.
REQ-010 SHALL have ports rdata1, rdata2  output  DATA_W  registered read data.
REQ-011 SHALL have port dbg_addr  input  ADDR_W  debug read address.
REQ-012 SHALL have port dbg_data  output  DATA_W  registered debug read data.
REQ-013 SHALL have port ready  output  1  high when the init sweep is complete and accesses are accepted.

Function
REQ-014 SHALL implement a two-state FSM: INIT and RUN.
REQ-015 While reset is high at a rising edge: state=INIT, init_cnt=0, ready=0, rdata1=rdata2=dbg_data=0, no array write.
REQ-016 In INIT, each edge with reset low: mem[init_cnt] = init_cnt zero-extended to DATA_W, then init_cnt+1; entry 0 = 0 when ZERO_REG=1.
REQ-017 The INIT edge that writes entry DEPTH-1 SHALL move state to RUN and set ready=1; ready rises exactly DEPTH edges after reset falls.
REQ-018 In INIT, we SHALL be ignored, and rdata1, rdata2 and dbg_data SHALL be held at 0.
REQ-019 Reset asserted mid-INIT or in RUN SHALL restart the sweep at init_cnt=0 on that edge; array contents are not cleared until rewritten by the sweep.
REQ-020 In RUN, an edge with we=1 SHALL write wdata to mem[waddr], except when ZERO_REG=1 and waddr=0, where the write is dropped.
REQ-021 Read ports SHALL have 1-cycle latency: rdataN after edge k = mem[raddrN] as sampled at edge k.
REQ-022 Write-to-read bypass: if we=1, waddr=raddrN and the write is not dropped in the same cycle, rdataN after that edge SHALL be wdata.
REQ-023 When ZERO_REG=1, raddrN=0 SHALL yield rdataN=0 regardless of bypass.
REQ-024 Both read ports SHALL be independent; equal addresses on both ports return identical data.
REQ-025 dbg_data SHALL have 1-cycle latency with no bypass: it returns the pre-write mem[dbg_addr] on a same-cycle write, and the new value one cycle later.
REQ-026 No combinational path SHALL exist from any input to any output.

Reset
REQ-027 Reset values: state=INIT, init_cnt=0, ready=0, rdata1=rdata2=dbg_data=0.
REQ-028 Post-sweep array contents (defaults): mem[i]=i for i=0..31.

Verification
REQ-029 Reset 1 cycle, then release -> ready=0 for edges 1-31, ready=1 after edge 32; raddr1=7, raddr2=31 -> rdata1=0x7, rdata2=0x1F next cycle.
REQ-030 RUN, we=1, waddr=3, wdata=0xDEADBEEF, raddr1=3, dbg_addr=3 same cycle -> rdata1=0xDEADBEEF, dbg_data=0x3; next cycle dbg_data=0xDEADBEEF.
REQ-031 RUN, we=1, waddr=0, wdata=0xFFFFFFFF, raddr1=raddr2=0 -> rdata1=rdata2=0 on that cycle and all later cycles.
REQ-032 Reset re-asserted at sweep edge 10 -> ready stays 0 and rises 32 edges after the second release; mem[5]=0x5.
REQ-033 INIT, we=1, waddr=4, wdata=0x1234 -> write ignored; after ready=1, raddr1=4 -> rdata1=0x4.
REQ-034 ADDR_W=3, DATA_W=8, ZERO_REG=0 -> ready after 8 edges; mem[0]=0 is writable: write 0xAB to address 0, then read -> 0xAB.
